// File: rtl/seq_row_mult_ctrl_pkg.sv
// Shared definitions for the sequential row multiplier: state encoding and
// the operand width the partial-product row is built for.
package seq_row_mult_ctrl_pkg;

    localparam int MULT_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Zero-extend a product to the accumulator width.
    function automatic logic [63:0] zext_prod(input logic [2*MULT_W-1:0] prod);
        return {{(64-2*MULT_W){1'b0}}, prod};
    endfunction

endpackage

// File: rtl/seq_row_mult_ctrl_array_levels.sv
// One partial-product row of an unsigned array multiplier.
// The row adds the gated multiplicand (a & b[i]) onto the incoming partial sum
// {cin, sin}; the 9-bit result comes out as {c, s}. The controller feeds the
// row one multiplier bit per clock and shifts the result right by one.
module array_levels
    import seq_row_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-2:0] sin,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] psum;
    logic [WIDTH:0]   total;

    // Partial-product bits: one AND gate per cell of the row.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            assign pp[gi] = a & b[gi];
        end
    endgenerate

    // The incoming sum: the top bit arrives on the carry input of the row.
    assign psum  = {cin, sin};
    assign total = {1'b0, psum} + {1'b0, pp};

    assign s = total[WIDTH-1:0];
    assign c = total[WIDTH];

endmodule

// File: rtl/seq_row_mult_ctrl.sv
// Sequential 8x8 unsigned multiply-accumulate controller.
// A single partial-product row is reused for 8 clocks (one per multiplier bit)
// instead of a full combinational array. Operands arrive on a valid/ready
// handshake, the product (and optional running accumulation) leaves on another.
module seq_row_mult_ctrl
    import seq_row_mult_ctrl_pkg::*;
#(
    parameter int WIDTH = MULT_W,
    parameter int ACC_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               acc_en,
    input  logic               acc_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic [ACC_W-1:0]   acc
);

    localparam int KW = $clog2(WIDTH);

    // Elaboration guards: the row cell is sized for 8-bit operands only.
    generate
        if (WIDTH != MULT_W) begin : g_bad_width
            $error("seq_row_mult_ctrl: WIDTH must be %0d", MULT_W);
        end
        if (ACC_W < 2*WIDTH) begin : g_bad_acc
            $error("seq_row_mult_ctrl: ACC_W must be >= 2*WIDTH");
        end
    endgenerate

    state_t state, state_nxt;

    logic [KW-1:0]      k;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               accen_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [2*WIDTH-1:0] p_r;
    logic [ACC_W-1:0]   acc_r;

    logic [WIDTH-1:0]   row_s;
    logic               row_c;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   lo_next;
    logic [2*WIDTH-1:0] prod_next;
    logic               accept;
    logic               last_iter;
    logic               acc_upd;
    logic [63:0]        prod_ext;

    assign accept    = (state == IDLE) && in_valid;
    assign last_iter = (k == KW'(WIDTH-1));
    assign acc_upd   = (state == RUN) && last_iter && accen_r;

    // Shared row: multiplier bit k gates the multiplicand onto the running sum.
    array_levels #(.WIDTH(WIDTH)) u_row (
        .a   (a_r[k]),
        .b   (b_r),
        .sin (hi_r[WIDTH-2:0]),
        .cin (hi_r[WIDTH-1]),
        .s   (row_s),
        .c   (row_c)
    );

    // Shift the row result right: the low bit retires into lo_r[k].
    always_comb begin
        hi_next    = {row_c, row_s[WIDTH-1:1]};
        lo_next    = lo_r;
        lo_next[k] = row_s[0];
        prod_next  = {hi_next, lo_next};
        prod_ext   = zext_prod(prod_next);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: fixed 8-iteration RUN, then hold DONE until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Operand capture and iteration datapath; p only moves on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k       <= '0;
            a_r     <= '0;
            b_r     <= '0;
            accen_r <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            p_r     <= '0;
        end else if (accept) begin
            k       <= '0;
            a_r     <= a;
            b_r     <= b;
            accen_r <= acc_en;
            hi_r    <= '0;
            lo_r    <= '0;
        end else if (state == RUN) begin
            k    <= k + 1'b1;
            hi_r <= hi_next;
            lo_r <= lo_next;
            if (last_iter) p_r <= prod_next;
        end
    end

    // Accumulator: clear wins over a same-cycle update; sum wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          acc_r <= '0;
        else if (acc_clr) acc_r <= '0;
        else if (acc_upd) acc_r <= acc_r + prod_ext[ACC_W-1:0];
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign p         = p_r;
    assign acc       = acc_r;

endmodule
